// File: rtl/posizione_oggetto_if.sv
// posizione_oggetto_if: frame marker, buttons and pause in; position and update pulse out
interface posizione_oggetto_if;
   logic        FINE_FRAME;
   logic        SINISTRA;
   logic        DESTRA;
   logic        SU;
   logic        GIU;
   logic        PAUSA;
   logic [10:0] X_POS;
   logic [10:0] Y_POS;
   logic        AGGIORNATO;
   modport master (output FINE_FRAME, SINISTRA, DESTRA, SU, GIU, PAUSA, input X_POS, Y_POS, AGGIORNATO);
   modport slave  (input FINE_FRAME, SINISTRA, DESTRA, SU, GIU, PAUSA, output X_POS, Y_POS, AGGIORNATO);
endinterface

// File: rtl/posizione_oggetto.sv
// posizione_oggetto: per-frame rectangle position, X wraps at H, Y clamped to 0..V-ALTEZZA;
// define POSIZIONE_RIMBALZO_EN for autonomous vertical bounce (SU/GIU then ignored)
module posizione_oggetto #(
   parameter int H          = 1280,
   parameter int V          = 1024,
   parameter int ALTEZZA    = 100,
   parameter int X_INIZIALE = 590,
   parameter int Y_INIZIALE = 462,
   parameter int PASSO      = 4,
   parameter int DIVISORE   = 2
) (
   input logic                CLK,
   input logic                RST,
   posizione_oggetto_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, SCRIVI} stato_t;
   localparam int CW = (DIVISORE > 1) ? $clog2(DIVISORE) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIVISORE - 1);
   localparam logic [11:0] H12   = 12'(H);
   localparam logic [11:0] P12   = 12'(PASSO);
   localparam logic [11:0] Y_MAX = 12'(V - ALTEZZA);

   stato_t        stato_q, stato_d;
   logic [1:0]    sin_q, des_q, su_q, giu_q;
   logic          f_prec_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [10:0]   x_q, x_d, y_q, y_d, x_nuovo_q, x_nuovo_d, y_nuovo_q, y_nuovo_d;
   logic          agg_q, agg_d;
   logic          fronte, vai_dx, vai_sx, vai_su, vai_giu;
   logic [11:0]   x12, y12, x_piu, x_meno, x_calc, y_piu, y_su, y_giu, y_calc;

   assign fronte = bus.FINE_FRAME & ~f_prec_q;
   assign vai_dx = des_q[1] & ~sin_q[1];
   assign vai_sx = sin_q[1] & ~des_q[1];
   assign x12    = {1'b0, x_q};
   assign y12    = {1'b0, y_q};
   assign x_piu  = x12 + P12;
   assign x_meno = x12 + H12 - P12;
   assign x_calc = vai_dx ? ((x_piu >= H12) ? x_piu - H12 : x_piu)
                 : vai_sx ? ((x12 < P12) ? x_meno : x12 - P12) : x12;
   assign y_piu  = y12 + P12;
   assign y_su   = (y12 < P12) ? 12'd0 : y12 - P12;
   assign y_giu  = (y_piu > Y_MAX) ? Y_MAX : y_piu;
   assign y_calc = vai_su ? y_su : vai_giu ? y_giu : y12;

`ifdef POSIZIONE_RIMBALZO_EN
   logic giu_dir_q;
   assign vai_giu = giu_dir_q;
   assign vai_su  = ~giu_dir_q;
   // direction flips for the next update once the clamped Y lands on a limit
   always_ff @(posedge CLK or posedge RST)
      if (RST) giu_dir_q <= 1'b1;
      else if (stato_q == CALC_Y) giu_dir_q <= giu_dir_q ? (y_giu != Y_MAX) : (y_su == 12'd0);
`else
   assign vai_su  = su_q[1] & ~giu_q[1];
   assign vai_giu = giu_q[1] & ~su_q[1];
`endif

   assign bus.X_POS      = x_q;
   assign bus.Y_POS      = y_q;
   assign bus.AGGIORNATO = agg_q;

   // frame pacing and the X -> Y -> write sequence; X and Y commit together in SCRIVI
   always_comb begin
      stato_d   = stato_q;
      cnt_d     = cnt_q;
      x_nuovo_d = x_nuovo_q;
      y_nuovo_d = y_nuovo_q;
      x_d       = x_q;
      y_d       = y_q;
      agg_d     = 1'b0;
      case (stato_q)
         IDLE: if (fronte && !bus.PAUSA) begin
            cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            stato_d = (cnt_q == CNT_MAX) ? CALC_X : IDLE;
         end
         CALC_X: begin
            x_nuovo_d = 11'(x_calc);
            stato_d   = CALC_Y;
         end
         CALC_Y: begin
            y_nuovo_d = 11'(y_calc);
            stato_d   = SCRIVI;
         end
         default: begin
            x_d     = x_nuovo_q;
            y_d     = y_nuovo_q;
            agg_d   = 1'b1;
            stato_d = IDLE;
         end
      endcase
   end

   // state, button synchronisers, frame marker history and outputs
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         stato_q   <= IDLE;
         sin_q     <= '0;
         des_q     <= '0;
         su_q      <= '0;
         giu_q     <= '0;
         f_prec_q  <= 1'b0;
         cnt_q     <= '0;
         x_nuovo_q <= 11'(X_INIZIALE);
         y_nuovo_q <= 11'(Y_INIZIALE);
         x_q       <= 11'(X_INIZIALE);
         y_q       <= 11'(Y_INIZIALE);
         agg_q     <= 1'b0;
      end else begin
         stato_q   <= stato_d;
         sin_q     <= {sin_q[0], bus.SINISTRA};
         des_q     <= {des_q[0], bus.DESTRA};
         su_q      <= {su_q[0], bus.SU};
         giu_q     <= {giu_q[0], bus.GIU};
         f_prec_q  <= bus.FINE_FRAME;
         cnt_q     <= cnt_d;
         x_nuovo_q <= x_nuovo_d;
         y_nuovo_q <= y_nuovo_d;
         x_q       <= x_d;
         y_q       <= y_d;
         agg_q     <= agg_d;
      end
endmodule

// File: doc/posizione_oggetto.md
# posizione_oggetto

Per-frame position generator for a movable on-screen rectangle. It holds the top-left corner `X_POS`/`Y_POS` consumed by the rectangle/frame hit-test stage, and updates it once per N frames from four direction buttons. Horizontal motion wraps around at `H`, matching the hit-test's wrap handling. Vertical motion is clamped so the rectangle always stays fully visible. The block sits between the video timing generator (frame marker) and the hit-test stage.

## Interface
- `H`, 1280: active width; X wrap modulus.
- `V`, 1024: active height.
- `ALTEZZA`, 100: rectangle height; the largest legal Y is `V-ALTEZZA`.
- `X_INIZIALE`, 590: X after reset.
- `Y_INIZIALE`, 462: Y after reset.
- `PASSO`, 4: pixels moved per update; must satisfy 1 ≤ PASSO < H and PASSO ≤ V-ALTEZZA.
- `DIVISORE`, 2: frames per update; must be ≥ 1.

Ports:
- `CLK`  in  1  pixel clock; the only clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `FINE_FRAME`  in  1  high during vertical blanking; synchronous to `CLK`.
- `SINISTRA`, `DESTRA`, `SU`, `GIU`  in  1 each  raw button levels, asynchronous.
- `PAUSA`  in  1  freezes motion and the frame counter; synchronous.
- `X_POS`  out  11  current X, always in 0..H-1.
- `Y_POS`  out  11  current Y, always in 0..V-ALTEZZA.
- `AGGIORNATO`  out  1  one-cycle pulse after each position write.

## Operation
- **Button synchronisation:** each button passes through its own 2-flop synchroniser. The FSM uses only the synchronised values.
- **Frame edge detection:** a register `f_prec` holds the previous `FINE_FRAME`. `edge = FINE_FRAME & ~f_prec`.
- **Frame counter:** `cnt_frame` runs 0..DIVISORE-1.
  - On `edge` in IDLE with `PAUSA`=0, it increments and wraps.
  - The update is triggered when `cnt_frame == DIVISORE-1` at the edge.
  - With `PAUSA`=1, edges are ignored and `cnt_frame` holds.
- **FSM states:**
  - IDLE → CALC_X on a triggering edge.
  - CALC_X → CALC_Y, unconditional.
  - CALC_Y → SCRIVI, unconditional.
  - SCRIVI → IDLE, unconditional.
  - Edges arriving outside IDLE are ignored and do not advance `cnt_frame`.
- **CALC_X** computes `x_nuovo` (12-bit internal arithmetic, no overflow):
  - DESTRA only: if `X+PASSO ≥ H`, then `X+PASSO-H`; else `X+PASSO`.
  - SINISTRA only: if `X < PASSO`, then `X+H-PASSO`; else `X-PASSO`.
  - Both or neither pressed: X is unchanged.
- **CALC_Y** computes `y_nuovo`:
  - SU only: if `Y < PASSO`, then 0; else `Y-PASSO`.
  - GIU only: if `Y+PASSO > V-ALTEZZA`, then `V-ALTEZZA`; else `Y+PASSO`.
  - Both or neither pressed: Y is unchanged.
- **SCRIVI:** `X_POS ← x_nuovo` and `Y_POS ← y_nuovo` in the same cycle. `AGGIORNATO` is asserted, registered, for exactly one cycle.
- **Reset values:**
  - `X_POS = X_INIZIALE`, `Y_POS = Y_INIZIALE`, `AGGIORNATO = 0`.
  - FSM = IDLE, `cnt_frame = 0`, `f_prec = 0`, synchronisers = 0.
- **Reset mid-operation:** `RST` in any state returns everything to the reset values immediately. A partially computed update is discarded.

## Timing
- The first `CLK` edge that samples `FINE_FRAME`=1 with `f_prec`=0 is edge n. If it triggers, the FSM is in CALC_X after edge n.
- `x_nuovo` is captured at edge n+1. `y_nuovo` is captured at edge n+2.
- `X_POS`/`Y_POS` change at edge n+3. `AGGIORNATO` is high from edge n+3 to edge n+4.
- Both outputs change together. The hit-test stage never sees a new X with an old Y.
- Button inputs affect the computation 2 cycles after they change (synchroniser latency). The values used are the synchronised ones present in CALC_X (for X) and CALC_Y (for Y).
- `FINE_FRAME` held high for many cycles produces exactly one edge.

## Configuration
- **`POSIZIONE_RIMBALZO_EN` defined:** vertical motion is autonomous.
  - A 1-bit direction register (reset = down) moves Y by `PASSO` each update.
  - On reaching a clamp limit (0 or `V-ALTEZZA`), Y is clamped and the direction flips for the next update.
  - `SU`/`GIU` are ignored; the ports remain present.
- **Not defined:** `SU`/`GIU` drive Y exactly as in CALC_Y above, and no direction register exists.

## Test plan
- **Reset:** assert `RST` mid-CALC_Y → `X_POS`=590, `Y_POS`=462, `AGGIORNATO`=0 immediately. Release `RST`, no edges → values hold.
- **Right wrap:** X=1278, DESTRA held, two frame edges (DIVISORE=2) → one update, X_POS=2 at edge n+3, one-cycle `AGGIORNATO`.
- **Left wrap:** X=2, SINISTRA held → X_POS=1278. With SINISTRA+DESTRA both held → X unchanged, `AGGIORNATO` still pulses.
- **Y clamp (macro off):** Y=922, GIU held → Y_POS=924. Y=2, SU held → Y_POS=0.
- **Pause and long marker:** `PAUSA`=1 across 5 edges → no `AGGIORNATO`, `cnt_frame` frozen. `FINE_FRAME` held high for 1000 cycles → at most one edge counted.
- **Bounce (macro on):** Y=922, no buttons → updates give 924, then 920. SU held from Y=462 → Y_POS=466, i.e. SU is ignored.
